// File: rtl/div_unit.sv
// Iterative 32-bit restoring divider: signed/unsigned, fixed 33-cycle latency.
// Magnitudes are divided, then quotient/remainder signs are fixed up in one cycle.
module div_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        sign,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] quo,
  output logic [31:0] rem,
  output logic        div_zero
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t       state;
  logic [4:0]   cnt;
  logic         sign_p0;
  logic         neg_a_p0;
  logic         neg_b_p0;
  logic         zero_p0;
  logic [31:0]  dvsr_p0;
  logic [31:0]  quo_p0;
  logic [32:0]  rem_p0;

  logic [32:0]        shifted;
  logic signed [32:0] trial;
  logic [31:0]        quo_fix;
  logic [31:0]        rem_fix;

  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

  // 32'h80000000 maps to unsigned 2^31, which still fits the 32-bit magnitude.
  function automatic logic [31:0] abs32(input logic signed [31:0] x);
    return x[31] ? neg32(x) : x;
  endfunction

  // One restoring step: a negative trial difference means the subtraction is undone.
  always_comb begin
    shifted = {rem_p0[31:0], quo_p0[31]};
    trial   = $signed(shifted - {1'b0, dvsr_p0});
  end

  always_comb begin
    quo_fix = quo_p0;
    rem_fix = rem_p0[31:0];
    if (sign_p0 && (neg_a_p0 ^ neg_b_p0)) quo_fix = neg32(quo_p0);
    if (sign_p0 && neg_a_p0)              rem_fix = neg32(rem_p0[31:0]);
    if (zero_p0)                          quo_fix = '1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      quo      <= '0;
      rem      <= '0;
      div_zero <= 1'b0;
      sign_p0  <= 1'b0;
      neg_a_p0 <= 1'b0;
      neg_b_p0 <= 1'b0;
      zero_p0  <= 1'b0;
      dvsr_p0  <= '0;
      quo_p0   <= '0;
      rem_p0   <= '0;
    end else if (flush) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state    <= CALC;
            busy     <= 1'b1;
            cnt      <= 5'd31;
            sign_p0  <= sign;
            neg_a_p0 <= sign & a[31];
            neg_b_p0 <= sign & b[31];
            zero_p0  <= (b == 32'd0);
            dvsr_p0  <= sign ? abs32(b) : b;
            quo_p0   <= sign ? abs32(a) : a;
            rem_p0   <= '0;
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          rem_p0 <= trial[32] ? shifted : $unsigned(trial);
          quo_p0 <= {quo_p0[30:0], ~trial[32]};
          cnt    <= cnt - 5'd1;
          if (cnt == 5'd0) state <= FIX;
        end
        FIX: begin
          quo      <= quo_fix;
          rem      <= rem_fix;
          div_zero <= zero_p0;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expected {quo, rem, div_zero} are queued when an
// operation is issued and popped when done is observed.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sign = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] quo;
  logic [31:0] rem;
  logic        div_zero;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int cyc = 0;
  logic [64:0] sb[$];

  div_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sign(sign), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .quo(quo), .rem(rem),
    .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  function automatic logic [64:0] model(input logic s, input logic [31:0] x, input logic [31:0] y);
    logic signed [31:0] sx, sy, q, r;
    if (y == 32'd0) return {32'hFFFFFFFF, x, 1'b1};
    if (!s) return {x / y, x % y, 1'b0};
    if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'h80000000, 32'd0, 1'b0};
    sx = x;
    sy = y;
    q = sx / sy;
    r = sx % sy;
    return {q, r, 1'b0};
  endfunction

  // Called at a falling edge; the following rising edge accepts the operation.
  task automatic drive_start(input logic s, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    sign  = s;
    a     = x;
    b     = y;
    sb.push_back(model(s, x, y));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int bc);
    lat = 0;
    bc  = 0;
    while (!done && lat < 100) begin
      if (busy) bc++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({busy, done, quo, rem, div_zero} !== 67'd0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%0b done=%0b quo=%h rem=%h dz=%0b, want all 0",
               busy, done, quo, rem, div_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int lat, bc;
    logic [64:0] exp;
    drive_start(1'b0, 32'd100, 32'd7);
    wait_done(lat, bc);
    exp = (sb.size() != 0) ? sb.pop_front() : '0;
    checks++;
    if (lat !== 33) begin
      errors++;
      $display("FAIL basic_latency: got %0d cycles, want 33", lat);
    end
    checks++;
    if (bc !== 33) begin
      errors++;
      $display("FAIL basic_busy_len: got %0d cycles, want 33", bc);
    end
    checks++;
    if ({done, quo, rem, div_zero} !== {1'b1, exp}) begin
      errors++;
      $display("FAIL basic_100_7: got done=%0b quo=%0d rem=%0d dz=%0b, want quo=%0d rem=%0d dz=%0b",
               done, quo, rem, div_zero, exp[64:33], exp[32:1], exp[0]);
    end
    checks++;
    if ({quo, rem} !== {32'd14, 32'd2}) begin
      errors++;
      $display("FAIL basic_const: got %0d r %0d, want 14 r 2", quo, rem);
    end
    @(negedge clk);
    checks++;
    if ({done, busy} !== 2'b00) begin
      errors++;
      $display("FAIL done_pulse: got done=%0b busy=%0b one cycle later, want 0 0", done, busy);
    end
  endtask

  task automatic test_values;
    int lat, bc;
    logic [64:0] exp;
    logic [31:0] ta[6] = '{32'hFFFFFFF9, 32'hFFFFFFFF, 32'h80000000, 32'd5, 32'hFFFFFFF7, 32'h7FFFFFFF};
    logic [31:0] tb[6] = '{32'd2,        32'd16,       32'hFFFFFFFF, 32'd0, 32'd0,       32'hFFFFFFFE};
    logic        ts[6] = '{1'b1,         1'b0,         1'b1,         1'b0,  1'b1,        1'b1};
    for (int i = 0; i < 6; i++) begin
      drive_start(ts[i], ta[i], tb[i]);
      wait_done(lat, bc);
      exp = (sb.size() != 0) ? sb.pop_front() : '0;
      checks++;
      if (lat !== 33 || {done, quo, rem, div_zero} !== {1'b1, exp}) begin
        errors++;
        $display("FAIL value_%0d: got lat=%0d quo=%h rem=%h dz=%0b, want lat=33 quo=%h rem=%h dz=%0b",
                 i, lat, quo, rem, div_zero, exp[64:33], exp[32:1], exp[0]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_flush;
    int lat, bc, d0;
    logic [31:0] pq, pr;
    logic pz;
    logic [64:0] exp;
    pq = quo; pr = rem; pz = div_zero; d0 = done_cnt;
    start = 1'b1; sign = 1'b1; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1; start = 1'b1; a = 32'd9; b = 32'd4;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    checks++;
    if ({busy, quo, rem, div_zero} !== {1'b0, pq, pr, pz}) begin
      errors++;
      $display("FAIL flush_state: got busy=%0b quo=%h rem=%h dz=%0b, want busy=0 quo=%h rem=%h dz=%0b",
               busy, quo, rem, div_zero, pq, pr, pz);
    end
    @(negedge clk);
    drive_start(1'b0, 32'd12345, 32'd10);
    wait_done(lat, bc);
    exp = (sb.size() != 0) ? sb.pop_front() : '0;
    checks++;
    if (lat !== 33 || {done, quo, rem, div_zero} !== {1'b1, exp}) begin
      errors++;
      $display("FAIL flush_restart: got lat=%0d quo=%0d rem=%0d, want lat=33 quo=%0d rem=%0d",
               lat, quo, rem, exp[64:33], exp[32:1]);
    end
    @(negedge clk);
    checks++;
    if (done_cnt !== d0 + 1) begin
      errors++;
      $display("FAIL flush_no_done: got %0d done pulses, want %0d", done_cnt - d0, 1);
    end
  endtask

  task automatic test_busy_ignore;
    int lat, bc, d0;
    logic [64:0] exp;
    drive_start(1'b1, 32'hFFFFFC18, 32'd7);
    repeat (5) @(negedge clk);
    start = 1'b1; sign = 1'b0; a = 32'd77; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bc);
    exp = (sb.size() != 0) ? sb.pop_front() : '0;
    checks++;
    if ({done, quo, rem, div_zero} !== {1'b1, exp}) begin
      errors++;
      $display("FAIL busy_ignore_result: got quo=%h rem=%h, want quo=%h rem=%h",
               quo, rem, exp[64:33], exp[32:1]);
    end
    d0 = done_cnt;
    repeat (40) @(negedge clk);
    checks++;
    if (done_cnt !== d0 + 1) begin
      errors++;
      $display("FAIL busy_ignore_extra: got %0d done pulses, want 1", done_cnt - d0);
    end
  endtask

  task automatic test_back_to_back;
    int lat, bc, c1, c2;
    logic [64:0] exp;
    drive_start(1'b0, 32'd1234567, 32'd89);
    wait_done(lat, bc);
    c1 = cyc;
    exp = (sb.size() != 0) ? sb.pop_front() : '0;
    checks++;
    if ({done, quo, rem, div_zero} !== {1'b1, exp}) begin
      errors++;
      $display("FAIL b2b_first: got quo=%0d rem=%0d, want quo=%0d rem=%0d",
               quo, rem, exp[64:33], exp[32:1]);
    end
    drive_start(1'b1, 32'hFFFFFFCE, 32'd6);
    wait_done(lat, bc);
    c2 = cyc;
    exp = (sb.size() != 0) ? sb.pop_front() : '0;
    checks++;
    if (c2 - c1 !== 34) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d cycles between done pulses, want 34", c2 - c1);
    end
    checks++;
    if ({done, quo, rem, div_zero} !== {1'b1, exp}) begin
      errors++;
      $display("FAIL b2b_second: got quo=%h rem=%h, want quo=%h rem=%h",
               quo, rem, exp[64:33], exp[32:1]);
    end
    @(negedge clk);
  endtask

  task automatic test_mid_reset;
    int lat, bc, d0;
    logic [64:0] exp;
    start = 1'b1; sign = 1'b0; a = 32'd5000; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, quo, rem, div_zero} !== 67'd0) begin
      errors++;
      $display("FAIL midreset_outputs: got busy=%0b done=%0b quo=%h rem=%h dz=%0b, want all 0",
               busy, done, quo, rem, div_zero);
    end
    d0 = done_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (45) @(negedge clk);
    checks++;
    if (done_cnt !== d0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_no_done: got %0d done pulses busy=%0b, want 0 pulses busy=0",
               done_cnt - d0, busy);
    end
    drive_start(1'b0, 32'd100, 32'd7);
    wait_done(lat, bc);
    exp = (sb.size() != 0) ? sb.pop_front() : '0;
    checks++;
    if (lat !== 33 || {done, quo, rem, div_zero} !== {1'b1, exp}) begin
      errors++;
      $display("FAIL midreset_fresh: got lat=%0d quo=%0d rem=%0d, want lat=33 quo=%0d rem=%0d",
               lat, quo, rem, exp[64:33], exp[32:1]);
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    int lat, bc;
    logic [64:0] exp;
    logic [31:0] x, y;
    logic s;
    for (int i = 0; i < 8; i++) begin
      s = 1'($urandom_range(1, 0));
      x = $urandom;
      y = (i % 3 == 0) ? 32'($urandom_range(20, 1)) : $urandom;
      if (i % 4 == 1) y = -y;
      drive_start(s, x, y);
      wait_done(lat, bc);
      exp = (sb.size() != 0) ? sb.pop_front() : '0;
      checks++;
      if (lat !== 33 || {done, quo, rem, div_zero} !== {1'b1, exp}) begin
        errors++;
        $display("FAIL random_%0d: s=%0b a=%h b=%h got lat=%0d quo=%h rem=%h, want lat=33 quo=%h rem=%h",
                 i, s, x, y, lat, quo, rem, exp[64:33], exp[32:1]);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_values();
    test_flush();
    test_busy_ignore();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-low reset.
REQ-002 SHALL have port `clk`, input, 1 bit: rising-edge clock for all state.
REQ-003 SHALL have port `rst_n`, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port `start`, input, 1 bit: request a division when the unit can accept.
REQ-005 SHALL have port `sign`, input, 1 bit: 1 = signed (div/mod), 0 = unsigned (divu/modu); sampled with `start`.
REQ-006 SHALL have port `a`, input, 32 bits: dividend; sampled with `start`.
REQ-007 SHALL have port `b`, input, 32 bits: divisor; sampled with `start`.
REQ-008 SHALL have port `flush`, input, 1 bit: cancel the in-flight operation (pipeline flush).
REQ-009 SHALL have port `busy`, output, 1 bit: operation in progress; new `start` is ignored.
REQ-010 SHALL have port `done`, output, 1 bit: single-cycle pulse; `quo`/`rem`/`div_zero` are valid.
REQ-011 SHALL have port `quo`, output, 32 bits: quotient, registered.
REQ-012 SHALL have port `rem`, output, 32 bits: remainder, registered.
REQ-013 SHALL have port `div_zero`, output, 1 bit: the last completed operation had `b` == 0.

Function
REQ-014 SHALL implement states IDLE, CALC, FIX and DONE.
REQ-015 SHALL accept `start` only in IDLE or DONE, with `flush` low; acceptance at edge k captures `sign`, |a|, |b|, the sign bits of a and b, loads iteration counter = 31, and enters CALC.
REQ-016 SHALL perform one restoring radix-2 step per edge in CALC (shift partial remainder, trial-subtract divisor, set quotient bit); at edges k+1..k+32 it completes 32 steps and leaves CALC for FIX after the step with counter = 0.
REQ-017 SHALL, in FIX at edge k+33, negate the quotient when the operand signs differ (signed mode only), negate the remainder when the dividend is negative (signed mode only), register `quo`/`rem`/`div_zero`, and enter DONE.
REQ-018 SHALL hold `done` high exactly for the cycle between edges k+33 and k+34; fixed latency is 33 cycles, independent of operand values.
REQ-019 SHALL go from DONE to IDLE at the next edge, or to CALC if a new `start` is accepted there (back-to-back, no bubble).
REQ-020 SHALL hold `busy` high in CALC and FIX, and low in IDLE and DONE.
REQ-021 SHALL ignore `start` while `busy` is high; no queuing.
REQ-022 SHALL use truncating division, so that a = quo*b + rem, |rem| < |b|, and the sign of rem equals the sign of a (or rem = 0).
REQ-023 SHALL, when b == 0, keep the same 33-cycle latency and produce `div_zero` = 1, `quo` = 32'hFFFFFFFF, `rem` = a, for both signed and unsigned modes.
REQ-024 SHALL, for signed 32'h80000000 / 32'hFFFFFFFF, produce `quo` = 32'h80000000, `rem` = 0, `div_zero` = 0 (wrap, no trap).
REQ-025 SHALL compute the absolute value of 32'h80000000 as unsigned 2^31 without overflow, using 33-bit internal remainder arithmetic.
REQ-026 SHALL, on `flush` high at an edge in any state, go to IDLE at that edge with no `done`, leaving `quo`/`rem`/`div_zero` unchanged.
REQ-027 SHALL give `flush` priority over `start` when both are high in the same cycle; the start is dropped.
REQ-028 SHALL hold `quo`, `rem` and `div_zero` stable from one `done` pulse until the next `done` pulse.

Reset
REQ-029 SHALL, while `rst_n` is low, immediately force state IDLE, `busy` = 0, `done` = 0, `quo` = 0, `rem` = 0, `div_zero` = 0 and counter = 0.
REQ-030 SHALL discard an in-flight operation on reset asserted mid-operation; no `done` is produced after release.
REQ-031 SHALL accept `start` at the first rising edge after `rst_n` deasserts.

Verification
REQ-032 Unsigned 100 / 7: start at edge k -> `done` only in the cycle after edge k+33, `quo` = 14, `rem` = 2, `busy` high for 33 cycles.
REQ-033 Signed -7 / 2 (a = 32'hFFFFFFF9, b = 2) -> `quo` = 32'hFFFFFFFD, `rem` = 32'hFFFFFFFF; unsigned 32'hFFFFFFFF / 16 -> `quo` = 32'h0FFFFFFF, `rem` = 15.
REQ-034 Signed 32'h80000000 / 32'hFFFFFFFF -> `quo` = 32'h80000000, `rem` = 0; a = 5, b = 0 -> `div_zero` = 1, `quo` = 32'hFFFFFFFF, `rem` = 5, at the same latency.
REQ-035 `flush` at k+10 with `start` also high -> `busy` = 0 from k+10, no `done`, `quo`/`rem` keep prior values; `start` at k+12 completes normally.
REQ-036 Back-to-back: second `start` in the DONE cycle -> second `done` exactly 34 cycles after the first, with correct results for both.
REQ-037 Reset: `rst_n` low at k+20 -> all outputs 0 immediately; no `done` after release; a fresh 100 / 7 then gives 14 r 2.
